maxpool3_ctrl: RTL

MAXPOOL3_CTRL -- requirements
Module: maxpool3_ctrl

---
 rtl/maxpool_pkg.sv | 26 ++
 rtl/comp_3.sv | 44 ++++
 rtl/maxpool3_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_pkg.sv
// Shared defaults, FSM state type and counter sizing for the 3x3 max-pool block.
package maxpool_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned MAX_WBLK_DEF = 16;
  localparam int unsigned MAX_HBLK_DEF = 16;

  // Pixel-in-block and row-in-band counters both run 0..2.
  localparam int unsigned PIX_CNT_W = 2;
  localparam int unsigned ROW_CNT_W = 2;

  localparam logic [PIX_CNT_W-1:0] PIX_LAST = 2'd2;
  localparam logic [ROW_CNT_W-1:0] ROW_LAST = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for an n-entry array; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comp_3.sv
// Three-input unsigned maximum with a registered result, valid one cycle after start.
module comp_3
  import maxpool_pkg::*;
#(
  parameter int unsigned in_length = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [in_length-1:0] i_in1,
  input  logic [in_length-1:0] i_in2,
  input  logic [in_length-1:0] i_in3,
  output logic [in_length-1:0] o_max,
  output logic                 o_valid
);

  logic [in_length-1:0] w_max12;
  logic [in_length-1:0] w_max;
  logic [in_length-1:0] r_max;
  logic                 r_valid;

  // Two-level unsigned compare tree.
  always_comb begin
    w_max12 = (i_in1 > i_in2) ? i_in1 : i_in2;
    w_max   = (i_in3 > w_max12) ? i_in3 : w_max12;
  end

  // Capture the maximum on start; valid follows start by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_max   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_start;
      if (i_start) begin
        r_max <= w_max;
      end
    end
  end

  assign o_max   = r_max;
  assign o_valid = r_valid;

endmodule

// File: rtl/maxpool3_ctrl.sv
// Streaming 3x3 stride-3 max-pool controller: horizontal max per block via comp_3,
// vertical max across a 3-row band via a one-row line buffer.
module maxpool3_ctrl
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WBLK = MAX_WBLK_DEF,
  parameter int unsigned MAX_HBLK = MAX_HBLK_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(MAX_WBLK+1)-1:0] cfg_wblk,
  input  logic [$clog2(MAX_HBLK+1)-1:0] cfg_hblk,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned CW_W  = $clog2(MAX_WBLK + 1);
  localparam int unsigned CH_W  = $clog2(MAX_HBLK + 1);
  localparam int unsigned LB_AW = idx_w(MAX_WBLK);

  state_t r_state;
  state_t w_state_d;

  logic [CW_W-1:0]      r_wblk;
  logic [CH_W-1:0]      r_hblk;
  logic [PIX_CNT_W-1:0] r_pix;
  logic [CW_W-1:0]      r_col;
  logic [ROW_CNT_W-1:0] r_row;
  logic [CH_W-1:0]      r_band;

  logic [DATA_W-1:0]    r_px0;
  logic [DATA_W-1:0]    r_px1;

  // Position tags travelling alongside the comparator result.
  logic [LB_AW-1:0]     r_res_col;
  logic [ROW_CNT_W-1:0] r_res_row;
  logic                 r_res_last;

  logic [DATA_W-1:0]    r_linebuf [MAX_WBLK];

  logic [DATA_W-1:0]    r_m_data;
  logic                 r_m_valid;
  logic                 r_m_last;

  logic                 w_start_acc;
  logic                 w_cfg_zero;
  logic                 w_stall;
  logic                 w_s_ready;
  logic                 w_accept;
  logic                 w_blk_end;
  logic                 w_col_end;
  logic                 w_row_end;
  logic                 w_band_end;
  logic                 w_comp_start;
  logic                 w_frame_end_px;
  logic                 w_out_hs;
  logic [DATA_W-1:0]    w_res;
  logic                 w_res_valid;
  logic [DATA_W-1:0]    w_lb_rd;
  logic [DATA_W-1:0]    w_merge;

  // Handshake and counter-boundary decode.
  always_comb begin
    w_start_acc    = (r_state == IDLE) && start;
    w_cfg_zero     = (cfg_wblk == '0) || (cfg_hblk == '0);
    w_stall        = r_m_valid && !m_ready;
    w_s_ready      = (r_state == RUN) && !w_stall;
    w_accept       = s_valid && w_s_ready;
    w_blk_end      = (r_pix == PIX_LAST);
    w_col_end      = (r_col == r_wblk - CW_W'(1));
    w_row_end      = (r_row == ROW_LAST);
    w_band_end     = (r_band == r_hblk - CH_W'(1));
    w_comp_start   = w_accept && w_blk_end;
    w_frame_end_px = w_comp_start && w_col_end && w_row_end && w_band_end;
    w_out_hs       = r_m_valid && m_ready;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state: DONE lasts exactly one cycle.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_d = w_cfg_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_out_hs && r_m_last) begin
          w_state_d = DONE;
        end
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Latch frame geometry only on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wblk <= '0;
      r_hblk <= '0;
    end else if (w_start_acc) begin
      r_wblk <= cfg_wblk;
      r_hblk <= cfg_hblk;
    end
  end

  // Raster position counters: pixel -> column block -> row-in-band -> band.
  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_pix  <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_band <= '0;
    end else if (w_accept) begin
      if (!w_blk_end) begin
        r_pix <= r_pix + PIX_CNT_W'(1);
      end else begin
        r_pix <= '0;
        if (!w_col_end) begin
          r_col <= r_col + CW_W'(1);
        end else begin
          r_col <= '0;
          if (!w_row_end) begin
            r_row <= r_row + ROW_CNT_W'(1);
          end else begin
            r_row  <= '0;
            r_band <= w_band_end ? '0 : r_band + CH_W'(1);
          end
        end
      end
    end
  end

  // Hold the first two pixels of a block until the third arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_px0 <= '0;
      r_px1 <= '0;
    end else if (w_accept) begin
      if (r_pix == PIX_CNT_W'(0)) begin
        r_px0 <= s_data;
      end
      if (r_pix == PIX_CNT_W'(1)) begin
        r_px1 <= s_data;
      end
    end
  end

  // Tag the in-flight comparator result with the block position it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_col  <= '0;
      r_res_row  <= '0;
      r_res_last <= 1'b0;
    end else if (w_comp_start) begin
      r_res_col  <= r_col[LB_AW-1:0];
      r_res_row  <= r_row;
      r_res_last <= w_frame_end_px;
    end
  end

  comp_3 #(
    .in_length (DATA_W)
  ) u_comp_3 (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_comp_start),
    .i_in1   (r_px0),
    .i_in2   (r_px1),
    .i_in3   (s_data),
    .o_max   (w_res),
    .o_valid (w_res_valid)
  );

  // Vertical merge of the new horizontal max with the partial column max.
  always_comb begin
    w_lb_rd = r_linebuf[r_res_col];
    w_merge = (w_lb_rd > w_res) ? w_lb_rd : w_res;
  end

  // Line buffer: row 0 seeds the column max, row 1 folds into it; no reset needed.
  always_ff @(posedge clk) begin
    if (w_res_valid && (r_res_row != ROW_LAST)) begin
      r_linebuf[r_res_col] <= (r_res_row == ROW_CNT_W'(0)) ? w_res : w_merge;
    end
  end

  // Output register: loads on row-2 results, clears on handshake. A load can never
  // coincide with a stall because the third pixel is refused while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_res_valid && (r_res_row == ROW_LAST)) begin
      r_m_data  <= w_merge;
      r_m_valid <= 1'b1;
      r_m_last  <= r_res_last;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s_ready = w_s_ready;
  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign busy    = (r_state == RUN) || (r_state == DONE);
  assign done    = (r_state == DONE);

endmodule
